// File: rtl/pulse_sched_pkg.sv
// rtl/pulse_sched_pkg.sv - shared types, defaults and width helper for the pulse round-robin scheduler
package pulse_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } sched_state_t;

    localparam int DEFAULT_N       = 4;
    localparam int DEFAULT_TIMEOUT = 255;

    // Never returns 0 so a degenerate count still yields a legal vector width.
    function automatic int width_for(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/req_edge_det.sv
// rtl/req_edge_det.sv - N-wide rising-edge detector on level requests
module req_edge_det #(
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [W-1:0] req,
    output logic [W-1:0] rise
);

    logic [W-1:0] req_prev;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            req_prev <= '0;
        end else begin
            req_prev <= req;
        end
    end

    assign rise = req & ~req_prev;

endmodule

// File: rtl/pulse_rr_scheduler.sv
// rtl/pulse_rr_scheduler.sv - round-robin sharing of one pulse-triggered resource among N requesters
module pulse_rr_scheduler
    import pulse_sched_pkg::*;
#(
    parameter int  N       = DEFAULT_N,
    parameter int  TIMEOUT = DEFAULT_TIMEOUT,
    localparam int CNT_W   = width_for(TIMEOUT + 1),
    localparam int ID_W    = width_for(N)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N-1:0]    req,
    input  logic            done,
    output logic            start,
    output logic [ID_W-1:0] grant_id,
    output logic            busy,
    output logic [N-1:0]    pending,
    output logic            ovf_pulse,
    output logic            timeout_pulse
);

    sched_state_t     state;
    logic [ID_W-1:0]  rr_ptr;
    logic [CNT_W-1:0] watchdog;
    logic [N-1:0]     rise;
    logic [N-1:0]     grant_mask;
    logic [N-1:0]     ovf_vec;
    logic [N-1:0]     pending_nxt;
    logic [ID_W:0]    pick;
    logic             do_grant;

    // Returns {found, index}; scanning downward lets the entry nearest rr_ptr win.
    function automatic logic [ID_W:0] rr_pick(input logic [N-1:0] pend, input logic [ID_W-1:0] ptr);
        logic [ID_W:0] res;
        int            idx;
        res = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (pend[idx]) begin
                res = {1'b1, ID_W'(idx)};
            end
        end
        return res;
    endfunction

    req_edge_det #(.W(N)) u_req_edge_det (
        .CLK  (CLK),
        .RST  (RST),
        .req  (req),
        .rise (rise)
    );

    assign pick        = rr_pick(pending, rr_ptr);
    assign do_grant    = (state == IDLE) && pick[ID_W];
    assign grant_mask  = do_grant ? (N'(1) << pick[ID_W-1:0]) : '0;
    // A fresh edge on the bit being granted re-arms it rather than counting as overflow.
    assign ovf_vec     = rise & pending & ~grant_mask;
    assign pending_nxt = (pending & ~grant_mask) | rise;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state         <= IDLE;
            start         <= 1'b0;
            grant_id      <= '0;
            busy          <= 1'b0;
            pending       <= '0;
            ovf_pulse     <= 1'b0;
            timeout_pulse <= 1'b0;
            rr_ptr        <= '0;
            watchdog      <= '0;
        end else begin
            pending       <= pending_nxt;
            ovf_pulse     <= |ovf_vec;
            timeout_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (do_grant) begin
                        grant_id <= pick[ID_W-1:0];
                        rr_ptr   <= (pick[ID_W-1:0] == ID_W'(N - 1)) ? '0 : pick[ID_W-1:0] + ID_W'(1);
                        start    <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    start    <= 1'b0;
                    watchdog <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (done) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (watchdog == CNT_W'(TIMEOUT - 1)) begin
                        busy          <= 1'b0;
                        timeout_pulse <= 1'b1;
                        state         <= IDLE;
                    end else if (watchdog != '1) begin
                        watchdog <= watchdog + CNT_W'(1);
                    end
                end
                default: begin
                    start <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_rr_scheduler.sv
// tb/tb_pulse_rr_scheduler.sv - self-checking bench for pulse_rr_scheduler
module tb_pulse_rr_scheduler;

    localparam int N       = 4;
    localparam int TIMEOUT = 8;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic [N-1:0] req = '0;
    logic         done = 1'b0;
    logic         start;
    logic [1:0]   grant_id;
    logic         busy;
    logic [N-1:0] pending;
    logic         ovf_pulse;
    logic         timeout_pulse;

    int vectors     = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    pulse_rr_scheduler #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .req           (req),
        .done          (done),
        .start         (start),
        .grant_id      (grant_id),
        .busy          (busy),
        .pending       (pending),
        .ovf_pulse     (ovf_pulse),
        .timeout_pulse (timeout_pulse)
    );

    // Reference: phase 0 = free, 1 = start issued, 2 = awaiting resource.
    int m_pend[N];
    int m_prev[N];
    int m_ptr, m_phase, m_elapsed;
    int m_start, m_gid, m_busy, m_ovf, m_to;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0;
            m_prev[i] = 0;
        end
        m_ptr = 0; m_phase = 0; m_elapsed = 0;
        m_start = 0; m_gid = 0; m_busy = 0; m_ovf = 0; m_to = 0;
    endtask

    task automatic model_step();
        int e[N];
        int winner;
        winner = -1;
        for (int i = 0; i < N; i++) e[i] = (req[i] && m_prev[i] == 0) ? 1 : 0;
        if (m_phase == 0) begin
            for (int k = 0; k < N; k++) begin
                if (winner < 0 && m_pend[(m_ptr + k) % N] != 0) winner = (m_ptr + k) % N;
            end
        end
        m_ovf = 0;
        for (int i = 0; i < N; i++) if (e[i] != 0 && m_pend[i] != 0 && i != winner) m_ovf = 1;
        for (int i = 0; i < N; i++) begin
            if (e[i] != 0) m_pend[i] = 1;
            else if (i == winner) m_pend[i] = 0;
        end
        m_to = 0;
        if (m_phase == 0) begin
            if (winner >= 0) begin
                m_phase = 1; m_start = 1; m_busy = 1; m_gid = winner;
                m_ptr = (winner + 1) % N;
            end
        end else if (m_phase == 1) begin
            m_phase = 2; m_start = 0; m_elapsed = 0;
        end else begin
            m_elapsed++;
            if (done) begin
                m_phase = 0; m_busy = 0;
            end else if (m_elapsed == TIMEOUT) begin
                m_phase = 0; m_busy = 0; m_to = 1;
            end
        end
        for (int i = 0; i < N; i++) m_prev[i] = req[i] ? 1 : 0;
    endtask

    always @(posedge CLK or negedge RST) begin
        if (!RST) model_reset();
        else model_step();
    end

    function automatic int m_pend_vec();
        int v;
        v = 0;
        for (int i = 0; i < N; i++) v |= (m_pend[i] << i);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            #3;
            chk("model_start", int'(start), m_start);
            chk("model_grant_id", int'(grant_id), m_gid);
            chk("model_busy", int'(busy), m_busy);
            chk("model_pending", int'(pending), m_pend_vec());
            chk("model_ovf", int'(ovf_pulse), m_ovf);
            chk("model_timeout", int'(timeout_pulse), m_to);
        end
    end

    task automatic nxt();
        @(negedge CLK);
        #1;
    endtask

    task automatic wait_start();
        for (int c = 0; c < 12 && !start; c++) nxt();
        chk("start_seen", int'(start), 1);
    endtask

    task automatic finish_grant();
        nxt(); nxt();
        done = 1'b1; nxt(); done = 1'b0;
    endtask

    int cnt, seen, extra;

    initial begin
        // Reset values
        repeat (3) nxt();
        chk("rst_start", int'(start), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pending", int'(pending), 0);
        chk("rst_grant_id", int'(grant_id), 0);
        chk("rst_ovf", int'(ovf_pulse), 0);
        chk("rst_timeout", int'(timeout_pulse), 0);
        RST = 1'b1; nxt();

        // Single request latency
        req = 4'b0100; nxt();
        chk("single_pending", int'(pending), 4);
        chk("single_no_start", int'(start), 0);
        nxt();
        chk("single_start", int'(start), 1);
        chk("single_gid", int'(grant_id), 2);
        chk("single_busy", int'(busy), 1);
        chk("single_cleared", int'(pending), 0);
        req = '0; nxt();
        chk("single_start_drop", int'(start), 0);
        chk("single_busy_hold", int'(busy), 1);
        repeat (5) nxt();
        done = 1'b1; nxt(); done = 1'b0;
        chk("single_done_busy", int'(busy), 0);

        // Reset while waiting with other requests pending
        req = 4'b0001; nxt(); req = '0; nxt();
        req = 4'b0110; nxt();
        chk("midwait_busy", int'(busy), 1);
        chk("midwait_pending", int'(pending), 6);
        req = '0; RST = 1'b0; nxt(); nxt();
        chk("midrst_start", int'(start), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_pending", int'(pending), 0);
        chk("midrst_gid", int'(grant_id), 0);
        RST = 1'b1;
        repeat (3) begin
            nxt();
            chk("post_rst_no_start", int'(start), 0);
        end

        // Round robin order and pointer wrap
        req = 4'b1111; nxt();
        chk("rr_pending", int'(pending), 15);
        for (int g = 0; g < N; g++) begin
            wait_start();
            chk("rr_order", int'(grant_id), g);
            finish_grant();
        end
        req = '0; nxt();
        req = 4'b0011; nxt();
        wait_start();
        chk("rr_wrap", int'(grant_id), 0);
        finish_grant();
        wait_start();
        chk("rr_wrap_next", int'(grant_id), 1);
        finish_grant();

        // Overflow while pending and not granted
        req = '0; nxt();
        req = 4'b0001; nxt(); nxt(); nxt();
        req = 4'b0011; nxt();
        chk("ovf_pending_set", int'(pending), 2);
        chk("ovf_none_yet", int'(ovf_pulse), 0);
        req = 4'b0001; nxt();
        req = 4'b0011; nxt();
        chk("ovf_pulse", int'(ovf_pulse), 1);
        chk("ovf_pending_kept", int'(pending), 2);
        nxt();
        chk("ovf_one_cycle", int'(ovf_pulse), 0);
        done = 1'b1; nxt(); done = 1'b0;
        nxt();
        chk("ovf_grant1", int'(start), 1);
        chk("ovf_grant1_id", int'(grant_id), 1);
        finish_grant();
        extra = 0;
        repeat (4) begin
            nxt();
            if (start) extra++;
        end
        chk("ovf_single_grant", extra, 0);

        // Edge on the bit being granted keeps it pending
        req = '0; nxt();
        req = 4'b0001; nxt(); nxt(); nxt();
        req = 4'b0011; nxt();
        req = 4'b0001; nxt();
        done = 1'b1; nxt(); done = 1'b0;
        req = 4'b0011; nxt();
        chk("same_start", int'(start), 1);
        chk("same_gid", int'(grant_id), 1);
        chk("same_pending", int'(pending), 2);
        chk("same_no_ovf", int'(ovf_pulse), 0);
        finish_grant();
        wait_start();
        chk("same_regrant", int'(grant_id), 1);
        finish_grant();

        // Watchdog expiry
        req = '0; nxt();
        req = 4'b0100; nxt(); nxt(); nxt();
        cnt = 0; seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            nxt();
            cnt++;
            if (timeout_pulse) seen = 1;
        end
        chk("to_seen", seen, 1);
        chk("to_cycles", cnt, TIMEOUT);
        chk("to_busy", int'(busy), 0);
        nxt();
        chk("to_one_cycle", int'(timeout_pulse), 0);

        // done on the expiry cycle wins
        req = '0; nxt();
        req = 4'b0100; nxt(); nxt(); nxt();
        repeat (TIMEOUT - 1) nxt();
        chk("to_edge_busy", int'(busy), 1);
        done = 1'b1; nxt(); done = 1'b0;
        chk("to_done_wins", int'(timeout_pulse), 0);
        chk("to_done_busy", int'(busy), 0);
        nxt();
        chk("to_done_later", int'(timeout_pulse), 0);

        // Stray done in IDLE and ISSUE
        req = '0; done = 1'b1; nxt();
        chk("stray_idle_busy", int'(busy), 0);
        req = 4'b1000; nxt();
        chk("stray_pending", int'(pending), 8);
        done = 1'b0; nxt();
        chk("stray_start", int'(start), 1);
        done = 1'b1; nxt(); done = 1'b0;
        chk("stray_issue_busy", int'(busy), 1);
        nxt();
        chk("stray_wait_busy", int'(busy), 1);
        done = 1'b1; nxt(); done = 1'b0;
        chk("stray_end_busy", int'(busy), 0);

        // Randomized traffic against the model
        repeat (800) begin
            for (int i = 0; i < N; i++) if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
            done = ($urandom_range(0, 5) == 0);
            RST  = ($urandom_range(0, 199) != 0);
            nxt();
        end
        RST = 1'b1; req = '0; done = 1'b0;
        repeat (3) nxt();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pulse_rr_scheduler.md
Name: pulse_rr_scheduler

Overview:
- Shares one pulse-triggered resource (e.g. a CDC transfer engine or single-shot unit) among N requesters.
- Each requester raises a level `req`. The block edge-detects it into a sticky pending bit and round-robin selects one pending requester.
- Issues a one-cycle `start` pulse with the winner's ID, then waits for the resource's `done` pulse, with a watchdog timeout.
- Sits between synchronized request lines and the shared resource; all inputs are already in the CLK domain.

Parameters:
- N, 4, number of requesters (2..16).
- TIMEOUT, 255, max cycles spent in WAIT before abort (≥1).
- CNT_W, $clog2(TIMEOUT+1), watchdog counter width (derived, not overridden).
- ID_W, $clog2(N), grant ID width (derived).

Ports:
- CLK  in  1  single clock; all logic posedge.
- RST  in  1  asynchronous, active-low reset.
- req  in  N  level requests, already synchronous to CLK; a rising edge means one service request.
- done  in  1  one-cycle completion pulse from the resource.
- start  out  1  one-cycle registered start pulse to the resource.
- grant_id  out  ID_W  registered index of the granted requester; valid from the start pulse until the next grant.
- busy  out  1  high in ISSUE and WAIT.
- pending  out  N  registered sticky pending vector.
- ovf_pulse  out  1  one-cycle pulse when a request edge arrives while that bit is already pending.
- timeout_pulse  out  1  one-cycle pulse when the watchdog expires.

Behaviour:
- Reset (RST=0, asynchronous) clears the following, regardless of state:
  - outputs: start, grant_id, busy, pending, ovf_pulse, timeout_pulse → 0;
  - internal: req_prev → 0, rr_ptr → 0, watchdog → 0, state → IDLE.
  - In-flight grants are silently dropped.
- Edge detect: per bit, `edge[i] = req[i] & ~req_prev[i]`; req_prev is registered every cycle.
- Pending update at each edge:
  - An edge sets `pending[i]`.
  - A grant to i clears `pending[i]`.
  - Edge and clear on the same bit in the same cycle: the bit stays 1, because a new event arrived.
  - Edge while `pending[i]` is already 1 and not being cleared: the event is dropped and `ovf_pulse` = 1 for one cycle.
- Round robin:
  - Search starts at rr_ptr and wraps modulo N; the first pending bit wins.
  - After a grant to i, rr_ptr = (i+1) mod N; wrap from N-1 goes to 0.
- FSM (state and outputs are registered):
  - IDLE: if any pending bit is set, then at the edge latch grant_id, clear that bit, update rr_ptr, set start=1 and busy=1, and go to ISSUE.
  - ISSUE: lasts exactly one cycle with start=1; next edge → WAIT, start=0, watchdog=0.
  - WAIT: each cycle watchdog +1.
    - done=1 → IDLE, busy=0.
    - Otherwise, watchdog reaching TIMEOUT-1 → IDLE, busy=0, timeout_pulse=1 for one cycle.
    - done and expiry in the same cycle: done wins, no timeout_pulse.
  - `done` in IDLE or ISSUE is ignored.
- Latency:
  - `req[i]` rising and sampled at edge k → pending[i]=1 after k → start=1 after k+1, for one cycle.
  - done sampled at edge j → next start can be high after j+1 at the earliest (IDLE lasts one cycle). Back-to-back grants therefore occupy 3 cycles plus the resource time.
- Width rules: grant_id is zero-extended; watchdog saturates and never wraps.

Decomposition:
- Shared package `pulse_sched_pkg`:
  - state enum constants IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2;
  - default N and TIMEOUT constants;
  - a clog2-based width helper.
- One natural sub-module, `req_edge_det`: an N-wide registered rising-edge detector with async active-low reset, instantiated once for `req`.
- The round-robin search stays inline as a combinational function.

Test Plan:
- Reset mid-WAIT (RST low for 2 cycles while busy=1, pending=4'b0110) → all outputs 0, state IDLE. After release, with no new edges, start stays 0.
- Single request: N=4, req[2] rises at edge 10 → pending=4'b0100 after edge 10; start=1 and grant_id=2 after edge 11; busy=1. done at edge 20 → busy=0 after edge 20.
- Round robin: req=4'b1111 rises together; each grant completes with done 3 cycles after start → grant order 0,1,2,3. Then req[0] re-pulses and gets the grant; rr_ptr wraps 3→0.
- Overflow and same-cycle rules:
  - req[1] toggles 0→1→0→1 while pending[1]=1 and not granted → ovf_pulse for exactly one cycle, pending[1] stays 1, only one grant to 1.
  - An edge on bit 1 in the same cycle as its grant → pending[1]=1 afterward.
- Timeout: TIMEOUT=8, no done after start → timeout_pulse exactly 8 cycles after entering WAIT, busy drops the same cycle. With done on that same expiry cycle → no timeout_pulse.
- Stray done: done pulses in IDLE and ISSUE → no state change, no early busy drop.
